mod_exp_engine: RTL and testbench

//  Sequential modular exponentiator: result = base^exponent mod modulus.

---
 rtl/mod_exp_engine.sv | 199 +++++++++++++++++++
 tb/tb_mod_exp_engine.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mod_exp_engine.sv
// Bit-serial modular exponentiator: result = base^exponent mod modulus.
// Ports: clk/rst, start, base/exponent/modulus in; busy, done, result, err out.
module mod_exp_engine #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] base,
   input  logic [WIDTH-1:0] exponent,
   input  logic [WIDTH-1:0] modulus,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             err
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] CLAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_REDUCE,
      S_EXP,
      S_FINISH
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] mod_q, mod_d;
   logic [WIDTH-1:0] exp_q, exp_d;
   logic [WIDTH-1:0] y_q, y_d;
   logic [WIDTH-1:0] r_q, r_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0] t_q, t_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [CW-1:0]    it_q, it_d;
   logic             ph_q, ph_d;
   logic             errp_q, errp_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic             err_q, err_d;

   // Running remainder stays below p, so WIDTH+1 bits hold every
   // intermediate of both the reduce step and the multiply step.
   logic [WIDTH:0]   p1;
   logic             ybit;
   logic [WIDTH:0]   red_sh, red_r;
   logic [WIDTH-1:0] mx;
   logic [WIDTH:0]   m1, m2, m3, m4;
   logic             last;
   logic [WIDTH-1:0] acc_init;
   logic [WIDTH-1:0] nacc;

   assign p1     = {1'b0, mod_q};
   assign ybit   = y_q[WIDTH-1];
   assign red_sh = {r_q, ybit};
   assign red_r  = (red_sh >= p1) ? red_sh - p1 : red_sh;

   // SQR phase multiplies acc by itself, MUL phase multiplies t by b.
   assign mx = ph_q ? t_q : acc_q;
   assign m1 = {r_q, 1'b0};
   assign m2 = (m1 >= p1) ? m1 - p1 : m1;
   assign m3 = ybit ? m2 + {1'b0, mx} : m2;
   assign m4 = (m3 >= p1) ? m3 - p1 : m3;

   assign last     = (cnt_q == CLAST);
   assign acc_init = (mod_q == WIDTH'(1)) ? '0 : WIDTH'(1);
   assign nacc     = exp_q[WIDTH-1] ? m4[WIDTH-1:0] : t_q;

   always_comb begin
      state_d  = state_q;
      mod_d    = mod_q;
      exp_d    = exp_q;
      y_d      = y_q;
      r_d      = r_q;
      b_d      = b_q;
      acc_d    = acc_q;
      t_d      = t_q;
      cnt_d    = cnt_q;
      it_d     = it_q;
      ph_d     = ph_q;
      errp_d   = errp_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      result_d = result_q;
      err_d    = err_q;
      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               mod_d = modulus;
               exp_d = exponent;
               y_d   = base;
               r_d   = '0;
               cnt_d = '0;
               it_d  = '0;
               ph_d  = 1'b0;
               if (modulus == '0) begin
                  errp_d  = 1'b1;
                  acc_d   = '0;
                  state_d = S_FINISH;
               end else begin
                  errp_d  = 1'b0;
                  state_d = S_REDUCE;
               end
            end
         end
         S_REDUCE: begin
            busy_d = 1'b1;
            r_d    = red_r[WIDTH-1:0];
            y_d    = y_q << 1;
            cnt_d  = last ? '0 : cnt_q + 1'b1;
            if (last) begin
               b_d     = red_r[WIDTH-1:0];
               acc_d   = acc_init;
               y_d     = acc_init;
               r_d     = '0;
               state_d = S_EXP;
            end
         end
         S_EXP: begin
            r_d   = m4[WIDTH-1:0];
            y_d   = y_q << 1;
            cnt_d = last ? '0 : cnt_q + 1'b1;
            if (last) begin
               r_d = '0;
               if (!ph_q) begin
                  t_d  = m4[WIDTH-1:0];
                  y_d  = b_q;
                  ph_d = 1'b1;
               end else begin
                  // Product always computed; the exponent bit only selects.
                  acc_d = nacc;
                  y_d   = nacc;
                  ph_d  = 1'b0;
                  exp_d = exp_q << 1;
                  it_d  = it_q + 1'b1;
                  if (it_q == CLAST) begin
                     state_d = S_FINISH;
                  end
               end
            end
         end
         S_FINISH: begin
            result_d = acc_q;
            err_d    = errp_q;
            done_d   = 1'b1;
            busy_d   = 1'b0;
            state_d  = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         mod_q    <= '0;
         exp_q    <= '0;
         y_q      <= '0;
         r_q      <= '0;
         b_q      <= '0;
         acc_q    <= '0;
         t_q      <= '0;
         cnt_q    <= '0;
         it_q     <= '0;
         ph_q     <= 1'b0;
         errp_q   <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         result_q <= '0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         mod_q    <= mod_d;
         exp_q    <= exp_d;
         y_q      <= y_d;
         r_q      <= r_d;
         b_q      <= b_d;
         acc_q    <= acc_d;
         t_q      <= t_d;
         cnt_q    <= cnt_d;
         it_q     <= it_d;
         ph_q     <= ph_d;
         errp_q   <= errp_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         result_q <= result_d;
         err_q    <= err_d;
      end
   end

   assign busy   = busy_q;
   assign done   = done_q;
   assign result = result_q;
   assign err    = err_q;

endmodule

// File: tb/tb_mod_exp_engine.sv
// Self-checking bench for mod_exp_engine.
// Random and directed jobs checked against a right-to-left power model.
module tb_mod_exp_engine;

   localparam int W = 32;
   localparam int LAT = 2 * W * W + W + 1;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [W-1:0] base;
   logic [W-1:0] exponent;
   logic [W-1:0] modulus;
   logic         busy;
   logic         done;
   logic [W-1:0] result;
   logic         err;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   mod_exp_engine #(.WIDTH(W)) dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .base    (base),
      .exponent(exponent),
      .modulus (modulus),
      .busy    (busy),
      .done    (done),
      .result  (result),
      .err     (err)
   );

   function automatic logic [W-1:0] ref_pow(input logic [W-1:0] b,
                                            input logic [W-1:0] e,
                                            input logic [W-1:0] p);
      logic [63:0] r, x, pp;
      if (p == 0) return '0;
      pp = {32'd0, p};
      r  = 64'd1 % pp;
      x  = {32'd0, b} % pp;
      for (int i = 0; i < W; i++) begin
         if (e[i]) r = (r * x) % pp;
         x = (x * x) % pp;
      end
      return r[W-1:0];
   endfunction

   // Called at a negedge; returns at the negedge where done is seen.
   task automatic run_job(input logic [W-1:0] b, input logic [W-1:0] e,
                          input logic [W-1:0] p,
                          output logic [W-1:0] res, output logic er,
                          output int n, output logic b0,
                          output logic b1, output logic bd);
      base = b;
      exponent = e;
      modulus = p;
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      @(negedge clk);
      b0 = busy;
      b1 = 1'b0;
      n = 0;
      do begin
         @(posedge clk);
         n++;
         @(negedge clk);
         if (n == 1) b1 = busy;
      end while (!done && n < 3000);
      res = result;
      er = err;
      bd = busy;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      start = 1'b0;
      base = '0;
      exponent = '0;
      modulus = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++;
      if (busy !== 1'b0) begin
         failures++;
         $display("FAIL reset_busy got=%b exp=0", busy);
      end
      checks++;
      if (done !== 1'b0) begin
         failures++;
         $display("FAIL reset_done got=%b exp=0", done);
      end
      checks++;
      if (result !== '0) begin
         failures++;
         $display("FAIL reset_result got=%h exp=0", result);
      end
      checks++;
      if (err !== 1'b0) begin
         failures++;
         $display("FAIL reset_err got=%b exp=0", err);
      end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_latency();
      logic [W-1:0] res;
      logic er, b0, b1, bd;
      int n;
      run_job(32'd3, 32'd5, 32'd7, res, er, n, b0, b1, bd);
      checks++;
      if (n != LAT) begin
         failures++;
         $display("FAIL latency got=%0d exp=%0d", n, LAT);
      end
      checks++;
      if (res !== 32'd5) begin
         failures++;
         $display("FAIL lat_result got=%0d exp=5", res);
      end
      checks++;
      if (er !== 1'b0) begin
         failures++;
         $display("FAIL lat_err got=%b exp=0", er);
      end
      checks++;
      if (b0 !== 1'b0 || b1 !== 1'b1 || bd !== 1'b0) begin
         failures++;
         $display("FAIL busy_window got=%b%b%b exp=010", b0, b1, bd);
      end
   endtask

   task automatic test_vectors();
      logic [W-1:0] vb[6] = '{32'd10, 32'd2, 32'd5, 32'd9, 32'd2, 32'hFFFFFFFF};
      logic [W-1:0] ve[6] = '{32'd3, 32'd10, 32'd0, 32'd7, 32'hFFFFFFFA, 32'd2};
      logic [W-1:0] vp[6] = '{32'd7, 32'd1000, 32'd13, 32'd1, 32'hFFFFFFFB,
                              32'hFFFFFFFB};
      logic [W-1:0] vr[6] = '{32'd6, 32'd24, 32'd1, 32'd0, 32'd1, 32'd16};
      logic [W-1:0] res;
      logic er, b0, b1, bd;
      int n;
      for (int i = 0; i < 6; i++) begin
         run_job(vb[i], ve[i], vp[i], res, er, n, b0, b1, bd);
         checks++;
         if (res !== vr[i] || er !== 1'b0 || n != LAT) begin
            failures++;
            $display("FAIL vector%0d got=%0d err=%b lat=%0d exp=%0d err=0 lat=%0d",
                     i, res, er, n, vr[i], LAT);
         end
      end
   endtask

   task automatic test_err();
      logic [W-1:0] res;
      logic er, b0, b1, bd;
      int n;
      run_job(32'd4, 32'd3, 32'd0, res, er, n, b0, b1, bd);
      checks++;
      if (n != 1) begin
         failures++;
         $display("FAIL err_latency got=%0d exp=1", n);
      end
      checks++;
      if (er !== 1'b1 || res !== '0) begin
         failures++;
         $display("FAIL err_flag got=%b res=%0d exp=1 res=0", er, res);
      end
      checks++;
      if (b1 !== 1'b0) begin
         failures++;
         $display("FAIL err_busy got=%b exp=0", b1);
      end
      run_job(32'd4, 32'd3, 32'd5, res, er, n, b0, b1, bd);
      checks++;
      if (er !== 1'b0 || res !== 32'd4 || n != LAT) begin
         failures++;
         $display("FAIL err_clear got=%b res=%0d lat=%0d exp=0 res=4 lat=%0d",
                  er, res, n, LAT);
      end
   endtask

   task automatic test_back_to_back();
      logic [W-1:0] res;
      logic er, b0, b1, bd;
      int n;
      run_job(32'd7, 32'd13, 32'd101, res, er, n, b0, b1, bd);
      run_job(32'd6, 32'd9, 32'd97, res, er, n, b0, b1, bd);
      checks++;
      if (n != LAT || res !== ref_pow(32'd6, 32'd9, 32'd97)) begin
         failures++;
         $display("FAIL back_to_back got=%0d lat=%0d exp=%0d lat=%0d",
                  res, n, ref_pow(32'd6, 32'd9, 32'd97), LAT);
      end
   endtask

   task automatic test_random();
      logic [W-1:0] res, b, e, p, ex;
      logic er, b0, b1, bd;
      int n;
      for (int i = 0; i < 6; i++) begin
         b = $urandom;
         e = $urandom;
         p = (i % 2 == 0) ? $urandom : $urandom_range(2, 1000);
         if (p == 0) p = 32'd3;
         ex = ref_pow(b, e, p);
         run_job(b, e, p, res, er, n, b0, b1, bd);
         checks++;
         if (res !== ex || er !== 1'b0 || n != LAT) begin
            failures++;
            $display("FAIL random%0d b=%h e=%h p=%h got=%h lat=%0d exp=%h",
                     i, b, e, p, res, n, ex);
         end
      end
   endtask

   task automatic test_ignore();
      logic [W-1:0] ex;
      int n;
      ex = ref_pow(32'd123457, 32'd65537, 32'd1000003);
      base = 32'd123457;
      exponent = 32'd65537;
      modulus = 32'd1000003;
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      n = 0;
      do begin
         @(posedge clk);
         n++;
         @(negedge clk);
         if (n == 100) begin
            base = 32'd99;
            exponent = 32'd2;
            modulus = 32'd0;
            start = 1'b1;
         end
         if (n == 101) start = 1'b0;
         if (n == 2000) start = 1'b1;
         if (n == 2001) start = 1'b0;
         if (n == LAT - 1) start = 1'b1;
         if (done) start = 1'b0;
      end while (!done && n < 3000);
      start = 1'b0;
      checks++;
      if (n != LAT) begin
         failures++;
         $display("FAIL ignore_latency got=%0d exp=%0d", n, LAT);
      end
      checks++;
      if (result !== ex || err !== 1'b0) begin
         failures++;
         $display("FAIL ignore_result got=%h err=%b exp=%h err=0",
                  result, err, ex);
      end
      repeat (3) @(negedge clk);
      checks++;
      if (busy !== 1'b0) begin
         failures++;
         $display("FAIL finish_start_ignored busy=%b exp=0", busy);
      end
   endtask

   task automatic test_reset_midjob();
      int n;
      int seen;
      base = 32'd3;
      exponent = 32'd5;
      modulus = 32'd7;
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      n = 0;
      while (n < 499) begin
         @(posedge clk);
         n++;
      end
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || result !== '0) begin
         failures++;
         $display("FAIL midjob_reset busy=%b done=%b res=%0d exp=0 0 0",
                  busy, done, result);
      end
      rst = 1'b0;
      seen = 0;
      for (int i = 0; i < LAT + 100; i++) begin
         @(negedge clk);
         if (done || busy) seen++;
      end
      checks++;
      if (seen != 0) begin
         failures++;
         $display("FAIL abandoned_job active_cycles=%0d exp=0", seen);
      end
   endtask

   initial begin
      test_reset();
      test_latency();
      test_vectors();
      test_err();
      test_back_to_back();
      test_random();
      test_ignore();
      test_reset_midjob();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
